// File: rtl/ysyx_22041211_mem_arbiter_if.sv
// rtl/ysyx_22041211_mem_arbiter_if.sv - request/response bundle between the masters, the arbiter and the shared SRAM port
interface ysyx_22041211_mem_arbiter_if #(
  parameter int NUM_MASTER = 2,
  parameter int DATA_LEN   = 32,
  parameter int ADDR_LEN   = 32,
  parameter int MASK_LEN   = 8
);
  logic [NUM_MASTER-1:0]          m_req_valid;
  logic [NUM_MASTER-1:0]          m_req_ready;
  logic [NUM_MASTER-1:0]          m_req_wen;
  logic [NUM_MASTER*ADDR_LEN-1:0] m_req_addr;
  logic [NUM_MASTER*DATA_LEN-1:0] m_req_wdata;
  logic [NUM_MASTER*MASK_LEN-1:0] m_req_mask;
  logic [NUM_MASTER-1:0]          m_rsp_valid;
  logic [DATA_LEN-1:0]            m_rsp_rdata;

  logic                           s_req_valid;
  logic                           s_req_ready;
  logic                           s_req_wen;
  logic [ADDR_LEN-1:0]            s_req_addr;
  logic [DATA_LEN-1:0]            s_req_wdata;
  logic [MASK_LEN-1:0]            s_req_mask;
  logic                           s_rsp_valid;
  logic [DATA_LEN-1:0]            s_rsp_rdata;

  modport arb (
    input  m_req_valid, m_req_wen, m_req_addr, m_req_wdata, m_req_mask,
    output m_req_ready, m_rsp_valid, m_rsp_rdata,
    output s_req_valid, s_req_wen, s_req_addr, s_req_wdata, s_req_mask,
    input  s_req_ready, s_rsp_valid, s_rsp_rdata
  );

  modport master (
    output m_req_valid, m_req_wen, m_req_addr, m_req_wdata, m_req_mask,
    input  m_req_ready, m_rsp_valid, m_rsp_rdata
  );

  modport slave (
    input  s_req_valid, s_req_wen, s_req_addr, s_req_wdata, s_req_mask,
    output s_req_ready, s_rsp_valid, s_rsp_rdata
  );
endinterface

// File: rtl/ysyx_22041211_mem_arbiter.sv
// rtl/ysyx_22041211_mem_arbiter.sv - N-master to 1-slave memory arbiter, one outstanding transaction
module ysyx_22041211_mem_arbiter #(
  parameter int DATA_LEN   = 32,
  parameter int ADDR_LEN   = 32,
  parameter int MASK_LEN   = 8,
  parameter int NUM_MASTER = 2,
  parameter int ARB_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  ysyx_22041211_mem_arbiter_if.arb bus,
  output logic                    proto_err
);
  localparam int IW = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic                  s_req_valid_q, s_req_valid_d;
  logic                  s_req_wen_q, s_req_wen_d;
  logic [ADDR_LEN-1:0]   s_req_addr_q, s_req_addr_d;
  logic [DATA_LEN-1:0]   s_req_wdata_q, s_req_wdata_d;
  logic [MASK_LEN-1:0]   s_req_mask_q, s_req_mask_d;
  logic [NUM_MASTER-1:0] m_rsp_valid_q, m_rsp_valid_d;
  logic [DATA_LEN-1:0]   m_rsp_rdata_q, m_rsp_rdata_d;
  logic                  proto_err_q, proto_err_d;

  logic [IW-1:0]         winner;
  logic                  any_valid;
  logic                  sel_wen;
  logic [ADDR_LEN-1:0]   sel_addr;
  logic [DATA_LEN-1:0]   sel_wdata;
  logic [MASK_LEN-1:0]   sel_mask;

  // Scan starts at the pointer in round-robin mode, at 0 in fixed-priority mode.
  always_comb begin : arbitrate
    int base;
    int idx;
    winner    = '0;
    any_valid = 1'b0;
    base      = (ARB_MODE == 1) ? int'(ptr_q) : 0;
    idx       = 0;
    for (int k = 0; k < NUM_MASTER; k++) begin
      idx = base + k;
      if (idx >= NUM_MASTER) idx = idx - NUM_MASTER;
      if (!any_valid && bus.m_req_valid[IW'(idx)]) begin
        any_valid = 1'b1;
        winner    = IW'(idx);
      end
    end
  end

  always_comb begin
    sel_wen   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_mask  = '0;
    for (int i = 0; i < NUM_MASTER; i++) begin
      if (winner == IW'(i)) begin
        sel_wen   = bus.m_req_wen[i];
        sel_addr  = bus.m_req_addr[i*ADDR_LEN +: ADDR_LEN];
        sel_wdata = bus.m_req_wdata[i*DATA_LEN +: DATA_LEN];
        sel_mask  = bus.m_req_mask[i*MASK_LEN +: MASK_LEN];
      end
    end
  end

  assign bus.m_req_ready = (state_q == IDLE && !rst && any_valid)
                         ? (NUM_MASTER'(1) << winner) : '0;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    s_req_valid_d = s_req_valid_q;
    s_req_wen_d   = s_req_wen_q;
    s_req_addr_d  = s_req_addr_q;
    s_req_wdata_d = s_req_wdata_q;
    s_req_mask_d  = s_req_mask_q;
    m_rsp_valid_d = '0;
    m_rsp_rdata_d = m_rsp_rdata_q;
    proto_err_d   = proto_err_q;
    case (state_q)
      IDLE: begin
        if (bus.s_rsp_valid) proto_err_d = 1'b1;
        // The s_req_* flops double as the request latch while in SEND.
        if (any_valid) begin
          state_d       = SEND;
          grant_d       = winner;
          ptr_d         = (int'(winner) == NUM_MASTER - 1) ? '0 : winner + 1'b1;
          s_req_valid_d = 1'b1;
          s_req_wen_d   = sel_wen;
          s_req_addr_d  = sel_addr;
          s_req_wdata_d = sel_wdata;
          s_req_mask_d  = sel_mask;
        end
      end
      SEND: begin
        if (bus.s_req_ready) begin
          s_req_valid_d = 1'b0;
          s_req_wen_d   = 1'b0;
          s_req_addr_d  = '0;
          s_req_wdata_d = '0;
          s_req_mask_d  = '0;
          if (bus.s_rsp_valid) begin
            state_d       = RESP;
            m_rsp_rdata_d = bus.s_rsp_rdata;
            m_rsp_valid_d = NUM_MASTER'(1) << grant_q;
          end else begin
            state_d = WAIT;
          end
        end else if (bus.s_rsp_valid) begin
          proto_err_d = 1'b1;
        end
      end
      WAIT: begin
        if (bus.s_rsp_valid) begin
          state_d       = RESP;
          m_rsp_rdata_d = bus.s_rsp_rdata;
          m_rsp_valid_d = NUM_MASTER'(1) << grant_q;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (bus.s_rsp_valid) proto_err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      ptr_q         <= '0;
      s_req_valid_q <= 1'b0;
      s_req_wen_q   <= 1'b0;
      s_req_addr_q  <= '0;
      s_req_wdata_q <= '0;
      s_req_mask_q  <= '0;
      m_rsp_valid_q <= '0;
      m_rsp_rdata_q <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      ptr_q         <= ptr_d;
      s_req_valid_q <= s_req_valid_d;
      s_req_wen_q   <= s_req_wen_d;
      s_req_addr_q  <= s_req_addr_d;
      s_req_wdata_q <= s_req_wdata_d;
      s_req_mask_q  <= s_req_mask_d;
      m_rsp_valid_q <= m_rsp_valid_d;
      m_rsp_rdata_q <= m_rsp_rdata_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign bus.s_req_valid = s_req_valid_q;
  assign bus.s_req_wen   = s_req_wen_q;
  assign bus.s_req_addr  = s_req_addr_q;
  assign bus.s_req_wdata = s_req_wdata_q;
  assign bus.s_req_mask  = s_req_mask_q;
  assign bus.m_rsp_valid = m_rsp_valid_q;
  assign bus.m_rsp_rdata = m_rsp_rdata_q;
  assign proto_err       = proto_err_q;
endmodule
